// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the ICache/DCache memory-port arbiter: FSM state
// encodings, owner identifiers and default bus widths.
package mem_bus_arbiter_pkg;

  localparam int MBA_ADDR_W = 32;
  localparam int MBA_DATA_W = 64;
  localparam int MBA_LEN_W  = 2;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_I_ADDR = 3'd1,
    ARB_D_ADDR = 3'd2,
    ARB_I_RD   = 3'd3,
    ARB_D_RD   = 3'd4,
    ARB_D_WR   = 3'd5,
    ARB_WAITB  = 3'd6
  } arb_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  function automatic logic arb_is_busy(input arb_state_e s);
    return s != ARB_IDLE;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Two-way round-robin select: a lone requester wins outright, a tie goes to
// whichever side did not own the previous transaction.
module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic last_owner_i,
  output logic valid_o,
  output logic owner_o
);

  always_comb begin
    valid_o = i_req_i | d_req_i;
    owner_o = OWNER_I;
    if (i_req_i && d_req_i) begin
      owner_o = (last_owner_i == OWNER_I) ? OWNER_D : OWNER_I;
    end else if (d_req_i) begin
      owner_o = OWNER_D;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the ICache refill path and the DCache path.
// Valid/ready: a transfer happens in a cycle where both sides are high.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = MBA_ADDR_W,
  parameter int DATA_W = MBA_DATA_W,
  parameter int LEN_W  = MBA_LEN_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [LEN_W-1:0]    i_len,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rlast,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [LEN_W-1:0]    d_len,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_wready,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rlast,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [LEN_W-1:0]    m_len,
  input  logic                m_ready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_wready,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rlast,
  input  logic                m_bvalid,
  output logic                busy
);

  arb_state_e           state_q;
  owner_e               last_owner_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [LEN_W-1:0]     len_q;
  logic                 we_q;
  logic [LEN_W-1:0]     cnt_q;

  logic pick_valid;
  logic pick_owner;
  logic early_close;

  mem_arb_pick u_pick (
    .i_req_i      (i_req),
    .d_req_i      (d_req),
    .last_owner_i (last_owner_q),
    .valid_o      (pick_valid),
    .owner_o      (pick_owner)
  );

  // The beat counter saturates at len so it only restarts on the IDLE reload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= OWNER_I;
      addr_q       <= '0;
      len_q        <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            cnt_q <= '0;
            if (pick_owner == OWNER_D) begin
              addr_q  <= d_addr;
              len_q   <= d_len;
              we_q    <= d_we;
              state_q <= ARB_D_ADDR;
            end else begin
              addr_q  <= i_addr;
              len_q   <= i_len;
              we_q    <= 1'b0;
              state_q <= ARB_I_ADDR;
            end
          end
        end
        ARB_I_ADDR: begin
          if (m_ready) state_q <= ARB_I_RD;
        end
        ARB_D_ADDR: begin
          if (m_ready) state_q <= we_q ? ARB_D_WR : ARB_D_RD;
        end
        ARB_I_RD, ARB_D_RD: begin
          if (m_rvalid) begin
            if (cnt_q != len_q) cnt_q <= cnt_q + 1'b1;
            if (m_rlast) begin
              state_q      <= ARB_IDLE;
              last_owner_q <= (state_q == ARB_I_RD) ? OWNER_I : OWNER_D;
            end
          end
        end
        ARB_D_WR: begin
          if (m_wready) begin
            if (cnt_q == len_q) begin
              state_q <= ARB_WAITB;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ARB_WAITB: begin
          if (m_bvalid) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= OWNER_D;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    i_gnt    = 1'b0;
    i_rvalid = 1'b0;
    i_rdata  = '0;
    i_rlast  = 1'b0;
    d_gnt    = 1'b0;
    d_wready = 1'b0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    d_rlast  = 1'b0;
    m_req    = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_len    = '0;
    m_wdata  = '0;
    m_wstrb  = '0;
    case (state_q)
      ARB_I_ADDR, ARB_D_ADDR: begin
        m_req  = 1'b1;
        m_we   = we_q;
        m_addr = addr_q;
        m_len  = len_q;
        i_gnt  = (state_q == ARB_I_ADDR) & m_ready;
        d_gnt  = (state_q == ARB_D_ADDR) & m_ready;
      end
      ARB_I_RD: begin
        i_rvalid = m_rvalid;
        i_rdata  = m_rdata;
        i_rlast  = m_rlast;
      end
      ARB_D_RD: begin
        d_rvalid = m_rvalid;
        d_rdata  = m_rdata;
        d_rlast  = m_rlast;
      end
      ARB_D_WR: begin
        m_wdata  = d_wdata;
        m_wstrb  = d_wstrb;
        d_wready = m_wready;
      end
      ARB_WAITB: begin
        d_rlast = m_bvalid;
      end
      default: ;
    endcase
  end

  assign busy = arb_is_busy(state_q);

  // A read burst closing before len+1 beats still frees the port; flag it.
  assign early_close = ((state_q == ARB_I_RD) || (state_q == ARB_D_RD)) &&
                       m_rvalid && m_rlast && (cnt_q != len_q);

  always @(posedge clk) begin
    if (rst) begin
      assert (!early_close)
        else $warning("mem_bus_arbiter: m_rlast before len+1 beats (addr %0h)", addr_q);
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: table of single transactions, contention,
// back-to-back, mid-burst reset and early-rlast sequences.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int LW = 2;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_gnt, i_rvalid, i_rlast;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_len;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_wready, d_rvalid, d_rlast;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_len;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [SW-1:0] d_wstrb;
  logic          m_req, m_we, m_ready, m_wready, m_rvalid, m_rlast, m_bvalid;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [SW-1:0] m_wstrb;
  logic          busy;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_wready(d_wready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_len(m_len),
    .m_ready(m_ready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wready(m_wready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .m_rlast(m_rlast), .m_bvalid(m_bvalid), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int i_gnt_n = 0;
  int d_gnt_n = 0;
  int d_bdone_n = 0;
  logic [DW:0] i_exp_q[$];
  logic [DW:0] d_exp_q[$];

  typedef struct {
    logic          is_d;
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            dly;
    int            wstall;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a, input int b);
    return {a ^ 32'h5A5A_0000, 32'h0000_1000 + 32'(b)};
  endfunction

  function automatic logic [DW-1:0] wr_word(input int b);
    return {32'hDEAD_0000 + 32'(b), 32'hBEEF_0000 + 32'(b)};
  endfunction

  function automatic logic [SW-1:0] wr_strb(input int b);
    return 8'hF0 ^ 8'(b);
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [DW:0] mon_e;
  logic        mon_i_any, mon_d_any;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (i_gnt) i_gnt_n++;
      if (d_gnt) d_gnt_n++;
      if (d_rlast && !d_rvalid) d_bdone_n++;
      mon_i_any = i_gnt | i_rvalid | i_rlast;
      mon_d_any = d_gnt | d_rvalid | d_rlast | d_wready;
      if (mon_i_any || mon_d_any) chk("exclusive_owner", 64'(mon_i_any & mon_d_any), 64'd0);
      if (i_rvalid) begin
        chk("i_beat_expected", 64'(i_exp_q.size() != 0), 64'd1);
        if (i_exp_q.size() != 0) begin
          mon_e = i_exp_q.pop_front();
          chk("i_rdata", i_rdata, mon_e[DW-1:0]);
          chk("i_rlast", 64'(i_rlast), 64'(mon_e[DW]));
        end
      end
      if (d_rvalid) begin
        chk("d_beat_expected", 64'(d_exp_q.size() != 0), 64'd1);
        if (d_exp_q.size() != 0) begin
          mon_e = d_exp_q.pop_front();
          chk("d_rdata", d_rdata, mon_e[DW-1:0]);
          chk("d_rlast", 64'(d_rlast), 64'(mon_e[DW]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    i_req = 0; i_addr = '0; i_len = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_len = '0; d_wdata = '0; d_wstrb = '0;
    m_ready = 0; m_wready = 0; m_rvalid = 0; m_rdata = '0; m_rlast = 0; m_bvalid = 0;
  endtask

  task automatic check_outputs_idle(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_m_req"}, 64'(m_req), 64'd0);
    chk({tag, "_gnts"}, 64'({i_gnt, d_gnt}), 64'd0);
    chk({tag, "_valids"}, 64'({i_rvalid, i_rlast, d_rvalid, d_rlast, d_wready}), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    i_exp_q.delete();
    d_exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_idle("reset");
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic push_reads(input logic is_d, input logic [AW-1:0] a, input int n, input int last_at);
    for (int k = 0; k < n; k++) begin
      if (is_d) d_exp_q.push_back({k == last_at, mem_word(a, k)});
      else      i_exp_q.push_back({k == last_at, mem_word(a, k)});
    end
  endtask

  task automatic set_req(input logic is_d, input logic we, input logic [AW-1:0] a,
                         input logic [LW-1:0] len);
    if (is_d) begin
      d_req = 1; d_we = we; d_addr = a; d_len = len;
      d_wdata = wr_word(0); d_wstrb = wr_strb(0);
      if (!we) push_reads(1'b1, a, int'(len) + 1, int'(len));
    end else begin
      i_req = 1; i_addr = a; i_len = len;
      push_reads(1'b0, a, int'(len) + 1, int'(len));
    end
  endtask

  task automatic accept(input int dly, input logic is_d, input logic we,
                        input logic [AW-1:0] a, input logic [LW-1:0] len);
    int n = 0;
    @(negedge clk);
    while (m_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("m_req_seen", 64'(m_req), 64'd1);
    if (m_req !== 1'b1) return;
    chk("m_addr", m_addr, a);
    chk("m_len", 64'(m_len), 64'(len));
    chk("m_we", 64'(m_we), 64'(we));
    for (int k = 0; k < dly; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("gnt_before_ready", 64'({i_gnt, d_gnt}), 64'd0);
    end
    @(posedge clk); #1;
    m_ready = 1;
    @(negedge clk);
    chk("gnt_owner", 64'({i_gnt, d_gnt}), is_d ? 64'd1 : 64'd2);
    @(posedge clk); #1;
    m_ready = 0;
    if (is_d) d_req = 0;
    else      i_req = 0;
    @(negedge clk);
    chk("gnt_one_pulse", 64'({i_gnt, d_gnt}), 64'd0);
  endtask

  task automatic read_beats(input logic [AW-1:0] a, input int n, input int last_at,
                            input logic raise_d, input logic [AW-1:0] ra, input logic [LW-1:0] rl);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      m_rvalid = 1; m_rdata = mem_word(a, k); m_rlast = (k == last_at);
      if (raise_d && k == n - 1) set_req(1'b1, 1'b0, ra, rl);
    end
    @(posedge clk); #1;
    m_rvalid = 0; m_rlast = 0; m_rdata = '0;
  endtask

  task automatic write_beats(input int len, input int stall0);
    for (int k = 0; k <= len; k++) begin
      @(posedge clk); #1;
      d_wdata = wr_word(k); d_wstrb = wr_strb(k); m_wready = 0;
      for (int s = 0; s < ((k == 0) ? stall0 : 0); s++) begin
        @(negedge clk);
        chk("d_wready_stall", 64'(d_wready), 64'd0);
        chk("m_wdata_stall", m_wdata, wr_word(k));
        @(posedge clk); #1;
      end
      m_wready = 1;
      @(negedge clk);
      chk("d_wready", 64'(d_wready), 64'd1);
      chk("m_wdata", m_wdata, wr_word(k));
      chk("m_wstrb", 64'(m_wstrb), 64'(wr_strb(k)));
    end
    @(posedge clk); #1;
    m_wready = 0;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      chk("d_rlast_wait_b", 64'(d_rlast), 64'd0);
      chk("busy_wait_b", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    m_bvalid = 1;
    @(negedge clk);
    chk("d_rlast_on_b", 64'(d_rlast), 64'd1);
    @(posedge clk); #1;
    m_bvalid = 0;
    @(negedge clk);
    chk("d_rlast_after_b", 64'(d_rlast), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int ig0 = i_gnt_n;
    int dg0 = d_gnt_n;
    int db0 = d_bdone_n;
    @(posedge clk); #1;
    set_req(v.is_d, v.we, v.addr, v.len);
    accept(v.dly, v.is_d, v.we, v.addr, v.len);
    if (v.is_d && v.we) write_beats(int'(v.len), v.wstall);
    else read_beats(v.addr, int'(v.len) + 1, int'(v.len), 1'b0, '0, '0);
    @(negedge clk);
    chk("vec_busy_idle", 64'(busy), 64'd0);
    chk("vec_i_q_drained", 64'(i_exp_q.size()), 64'd0);
    chk("vec_d_q_drained", 64'(d_exp_q.size()), 64'd0);
    chk("vec_i_gnt_count", 64'(i_gnt_n - ig0), v.is_d ? 64'd0 : 64'd1);
    chk("vec_d_gnt_count", 64'(d_gnt_n - dg0), v.is_d ? 64'd1 : 64'd0);
    chk("vec_write_done_count", 64'(d_bdone_n - db0), (v.is_d && v.we) ? 64'd1 : 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  vec_t vecs[6];
  vec_t rv;

  initial begin
    vecs[0] = '{is_d: 1'b0, we: 1'b0, addr: 32'h8000_0000, len: 2'd3, dly: 2, wstall: 0};
    vecs[1] = '{is_d: 1'b1, we: 1'b1, addr: 32'h0000_1000, len: 2'd1, dly: 0, wstall: 3};
    vecs[2] = '{is_d: 1'b1, we: 1'b0, addr: 32'h0000_2040, len: 2'd0, dly: 1, wstall: 0};
    vecs[3] = '{is_d: 1'b0, we: 1'b0, addr: 32'h8000_0100, len: 2'd0, dly: 0, wstall: 0};
    vecs[4] = '{is_d: 1'b1, we: 1'b1, addr: 32'h0000_3000, len: 2'd3, dly: 1, wstall: 0};
    vecs[5] = '{is_d: 1'b1, we: 1'b0, addr: 32'h0000_4000, len: 2'd3, dly: 0, wstall: 0};

    do_reset();

    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    for (int r = 0; r < 4; r++) begin
      rv.is_d   = 1'($urandom_range(0, 1));
      rv.we     = rv.is_d & 1'($urandom_range(0, 1));
      rv.addr   = 32'($urandom_range(0, 32'h0FFF_FFFF)) << 3;
      rv.len    = 2'($urandom_range(0, 3));
      rv.dly    = $urandom_range(0, 3);
      rv.wstall = $urandom_range(0, 2);
      run_vec(rv);
    end

    // Contention straight after reset: dcache first, then icache, then dcache.
    do_reset();
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'h8000_1000, 2'd1);
    set_req(1'b1, 1'b0, 32'h0000_5000, 2'd2);
    accept(1, 1'b1, 1'b0, 32'h0000_5000, 2'd2);
    read_beats(32'h0000_5000, 3, 2, 1'b0, '0, '0);
    accept(0, 1'b0, 1'b0, 32'h8000_1000, 2'd1);
    read_beats(32'h8000_1000, 2, 1, 1'b0, '0, '0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'h8000_2000, 2'd0);
    set_req(1'b1, 1'b0, 32'h0000_6000, 2'd1);
    accept(0, 1'b1, 1'b0, 32'h0000_6000, 2'd1);
    read_beats(32'h0000_6000, 2, 1, 1'b0, '0, '0);
    accept(0, 1'b0, 1'b0, 32'h8000_2000, 2'd0);
    read_beats(32'h8000_2000, 1, 0, 1'b0, '0, '0);
    @(negedge clk);
    chk("contention_idle", 64'(busy), 64'd0);

    // Back-to-back: d_req rises in the i_rlast cycle -> exactly one idle cycle.
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'h8000_3000, 2'd1);
    accept(0, 1'b0, 1'b0, 32'h8000_3000, 2'd1);
    read_beats(32'h8000_3000, 2, 1, 1'b1, 32'h0000_7000, 2'd0);
    @(negedge clk);
    chk("b2b_bubble_busy", 64'(busy), 64'd0);
    chk("b2b_bubble_m_req", 64'(m_req), 64'd0);
    @(negedge clk);
    chk("b2b_busy_again", 64'(busy), 64'd1);
    chk("b2b_m_req", 64'(m_req), 64'd1);
    accept(0, 1'b1, 1'b0, 32'h0000_7000, 2'd0);
    read_beats(32'h0000_7000, 1, 0, 1'b0, '0, '0);

    // Asynchronous reset in the middle of an icache burst.
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'h8000_4000, 2'd3);
    accept(0, 1'b0, 1'b0, 32'h8000_4000, 2'd3);
    read_beats(32'h8000_4000, 2, 99, 1'b0, '0, '0);
    @(posedge clk); #1;
    m_rvalid = 1; m_rdata = mem_word(32'h8000_4000, 2);
    #2;
    rst = 1'b0;
    #1;
    check_outputs_idle("async_rst");
    i_exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    m_rdata = mem_word(32'h8000_4000, 3); m_rlast = 1;
    @(negedge clk);
    chk("stale_beat_dropped", 64'({i_rvalid, d_rvalid, i_rlast, d_rlast}), 64'd0);
    chk("stale_beat_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    m_rvalid = 0; m_rlast = 0;
    run_vec(vecs[3]);

    // Early m_rlast on beat 1 of a 4-beat read still closes the transaction.
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h8000_5000; i_len = 2'd3;
    push_reads(1'b0, 32'h8000_5000, 2, 1);
    accept(0, 1'b0, 1'b0, 32'h8000_5000, 2'd3);
    read_beats(32'h8000_5000, 2, 1, 1'b0, '0, '0);
    @(negedge clk);
    chk("early_rlast_idle", 64'(busy), 64'd0);
    chk("early_rlast_q", 64'(i_exp_q.size()), 64'd0);
    run_vec(vecs[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
